edge_filter3x3: RTL and testbench
=================================

# edge_filter3x3

Parametrised streaming 3×3 edge filter between two first-word-fall-through (FWFT) pixel FIFOs in the edge-detection pipeline. It is the successor of the fixed 8-bit Sobel stage and adds:

- configurable pixel width, gradient scaling and image size
- run-time mode select: Sobel, Prewitt, thresholded Sobel, pass-through
- one pixel per clock throughput
- automatic end-of-frame flush and back-to-back frames

It emits exactly IMG_WIDTH×IMG_HEIGHT output pixels per frame, in raster order.

## Interface
- IMG_WIDTH, 720, pixels per row (≥3)
- IMG_HEIGHT, 576, rows per frame (≥3)
- PX_WIDTH, 8, bits per pixel
- GRAD_SHIFT, 1, right shift applied to |gx|+|gy|
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- in_empty  in  1  upstream FIFO empty
- in_dout  in  PX_WIDTH  upstream head pixel; valid while !in_empty
- in_rd_en  out  1  pop upstream, combinational
- out_full  in  1  downstream FIFO full
- out_wr_en  out  1  push downstream, combinational
- out_din  out  PX_WIDTH  output pixel; 0 when !out_wr_en
- mode  in  2  0 Sobel, 1 Prewitt, 2 thresholded Sobel, 3 pass-through
- threshold  in  PX_WIDTH  compare level for mode 2
- frame_done  out  1  one-cycle pulse, registered, in the cycle after the last pixel of a frame is written

## Operation
- **Window.** A 3×3 window of registers holds pixel columns; two line buffers hold the previous two rows.
- **Advance.** Each advance shifts in one column:
  - top and middle pixels come from the line buffers
  - bottom pixel is in_dout; during flush it is 0
  - the bottom pixel is written into the line buffer at the current column
- **Position counter.** k counts advances within the frame, 0 … N+W+1, where N=W·H. Column and row counters track the pixel being shifted in.
- **States:**
  - S_FILL (k < W+2): advance = !in_empty. Reads only, no write. Go to S_RUN when k reaches W+2.
  - S_RUN: advance = !in_empty && !out_full. Read and write together. Go to S_FLUSH after the N-th read.
  - S_FLUSH: advance = !out_full. Writes only, no read. After the W+2-th flush write: return to S_FILL, k=0, pulse frame_done.
- **Output index.** The write in an advance outputs centre index k−W−2 from the window state *before* the shift.
- **Border.** A centre at row 0, row H−1, column 0 or column W−1 outputs 0 in modes 0–2. Stale cross-row or previous-frame data therefore never leaks.
- **Mode 3 (pass-through).** Outputs the centre pixel unchanged, including border pixels.
- **Mode latching.** mode and threshold are latched when k=0 advances and held for the whole frame. Changes mid-frame take effect at the next frame.
- **Arithmetic:**
  - gx, gy: signed, PX_WIDTH+4 bits
  - Sobel weights 1,2,1; Prewitt weights 1,1,1
  - mag = (|gx|+|gy|) >> GRAD_SHIFT, computed at PX_WIDTH+5 bits, saturated to 2^PX_WIDTH−1
  - mode 2 outputs all-ones if mag ≥ threshold, else 0

## Timing
- **Reset values:** in_rd_en=0, out_wr_en=0, out_din=0, frame_done=0, state=S_FILL, k=0, window=0.
- **Reset mid-frame:** the partial frame is abandoned. Outputs deassert in the cycle rst is high. The next pixel read is treated as pixel 0. Line buffers are not cleared.
- **Throughput:** 1 pixel/clock when unstalled.
- **Latency:** the first output is written in the same cycle the W+3-th input pixel is read.
- **Stalls:** in_empty or out_full (per state rules above) freeze every register. Nothing is popped or pushed in that cycle.
- **Line-buffer read address** = next column (combinational column count). Synchronous-read data for the column being shifted in is therefore ready in the advancing cycle.
- **Next frame:** the first pixel of frame n+1 may be read in the cycle after the last flush write. There are no idle cycles beyond that.

## Structure
- Package edge_filter_pkg holds:
  - mode_t enum (MODE_SOBEL, MODE_PREWITT, MODE_THRESH, MODE_PASS)
  - state_t (S_FILL, S_RUN, S_FLUSH)
  - width helper functions
- One sub-module, line_buffer: simple dual-port synchronous BRAM, depth IMG_WIDTH, width PX_WIDTH. It is instantiated twice, with roles rotated at row end.
- Gradient and magnitude logic is a combinational function in the package.

## Test plan
All scenarios use W=8, H=6, PX_WIDTH=8, GRAD_SHIFT=1 unless stated.

1. Constant image of 100, mode 0 → 48 writes, all 0; exactly one frame_done, one cycle after the 48th write.
2. Vertical step (cols 0–3 = 0, cols 4–7 = 50), mode 0 → rows 1–4, cols 3 and 4 = 100; all else 0.
3. Same step image:
   - mode 1 → those positions = 75
   - mode 2 with threshold=90 → 255
   - mode 2 with threshold=101 → 0
4. Ramp image (pixel = raster index), mode 3 → output sequence equals 0…47. The first write coincides with reading pixel 10.
5. Random in_empty/out_full stalls, two back-to-back frames, mode changed 0→1 mid-frame 1:
   - frame 1 matches the mode-0 model, frame 2 matches the mode-1 model
   - no lost or duplicated pixels; 96 writes total
6. rst asserted after 20 pixels read → outputs deassert in the same cycle; the following full frame yields the correct 48 outputs.

Source files
------------

// File: rtl/edge_filter3x3_pkg.sv
// edge_filter_pkg: shared types and gradient arithmetic for edge_filter3x3.
// No ports. Provides mode_t, state_t, a counter width helper and grad_mag().
package edge_filter_pkg;

    typedef enum logic [1:0] {
        MODE_SOBEL   = 2'd0,
        MODE_PREWITT = 2'd1,
        MODE_THRESH  = 2'd2,
        MODE_PASS    = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        S_FILL,
        S_RUN,
        S_FLUSH
    } state_t;

    // Widest pixel the shared gradient function handles; narrower
    // pixels are zero-extended and the constant upper bits fold away.
    localparam int PXW_MAX = 16;
    localparam int GW      = PXW_MAX + 5;

    typedef logic [PXW_MAX-1:0] pix_t;
    // Element r*3+c: row 0 is the top row, column 0 the oldest column.
    typedef logic [8:0][PXW_MAX-1:0] win_t;

    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // (|gx|+|gy|) >> shift, saturated to lim.
    function automatic pix_t grad_mag(
        input win_t       w,
        input logic       prewitt,
        input pix_t       lim,
        input logic [4:0] shift
    );
        logic signed [GW-1:0] v [9];
        logic signed [GW-1:0] l, r, t, b, gx, gy;
        logic [GW-1:0]        sum, mag;
        for (int i = 0; i < 9; i++) begin
            v[i] = $signed({5'b0, w[i]});
        end
        l   = v[0] + v[6] + (prewitt ? v[3] : v[3] <<< 1);
        r   = v[2] + v[8] + (prewitt ? v[5] : v[5] <<< 1);
        t   = v[0] + v[2] + (prewitt ? v[1] : v[1] <<< 1);
        b   = v[6] + v[8] + (prewitt ? v[7] : v[7] <<< 1);
        gx  = r - l;
        gy  = b - t;
        sum = $unsigned(gx < 0 ? -gx : gx)
            + $unsigned(gy < 0 ? -gy : gy);
        mag = sum >> shift;
        if (mag > {5'b0, lim}) begin
            mag = {5'b0, lim};
        end
        return mag[PXW_MAX-1:0];
    endfunction

endpackage

// File: rtl/edge_filter3x3_if.sv
// edge_filter3x3_if: FWFT upstream pop side and downstream push side.
// master = filter (reads in_*, drives rd/wr/din); slave = FIFO side.
interface edge_filter3x3_if #(
    parameter int PX_WIDTH = 8
);
    logic                in_empty;
    logic [PX_WIDTH-1:0] in_dout;
    logic                in_rd_en;
    logic                out_full;
    logic                out_wr_en;
    logic [PX_WIDTH-1:0] out_din;

    modport master (
        input  in_empty, in_dout, out_full,
        output in_rd_en, out_wr_en, out_din
    );

    modport slave (
        output in_empty, in_dout, out_full,
        input  in_rd_en, out_wr_en, out_din
    );
endinterface

// File: rtl/edge_filter3x3_line_buffer.sv
// line_buffer: simple dual-port RAM, one write and one registered read.
// Ports: clk, we_i/waddr_i/wdata_i write side, raddr_i -> rdata_o next clk.
module line_buffer #(
    parameter int DEPTH = 720,
    parameter int WIDTH = 8,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/edge_filter3x3.sv
// edge_filter3x3: streaming 3x3 Sobel/Prewitt/threshold/pass filter.
// Ports: clk, rst, fifo (FWFT in / push out), mode, threshold, frame_done.
module edge_filter3x3
    import edge_filter_pkg::*;
#(
    parameter int IMG_WIDTH  = 720,
    parameter int IMG_HEIGHT = 576,
    parameter int PX_WIDTH   = 8,
    parameter int GRAD_SHIFT = 1
) (
    input  logic                clk,
    input  logic                rst,
    edge_filter3x3_if.master    fifo,
    input  logic [1:0]          mode,
    input  logic [PX_WIDTH-1:0] threshold,
    output logic                frame_done
);
    localparam int W    = IMG_WIDTH;
    localparam int H    = IMG_HEIGHT;
    localparam int N    = W * H;
    localparam int KMAX = N + W + 1;
    localparam int KW   = cnt_w(KMAX + 1);
    localparam int CW   = cnt_w(W);
    localparam int RW   = cnt_w(H);
    localparam logic [PX_WIDTH-1:0] PX_MAX = '1;

    state_t              state_q;
    logic [KW-1:0]       k_q;
    logic [CW-1:0]       col_q, col_d, col_nx;
    logic                sel_q;
    logic [CW-1:0]       ccol_q;
    logic [RW-1:0]       crow_q;
    mode_t               mode_q;
    logic [PX_WIDTH-1:0] thr_q;
    logic [PX_WIDTH-1:0] win_q [3][3];
    logic                frame_done_q;

    logic                adv, rd, wr, last, border;
    logic [PX_WIDTH-1:0] bot, top, mid, lb0_rd, lb1_rd, px;
    win_t                win_p;
    pix_t                mag_full;

    always_comb begin
        adv = 1'b0;
        rd  = 1'b0;
        wr  = 1'b0;
        if (!rst) begin
            unique case (state_q)
                S_FILL: begin
                    adv = !fifo.in_empty;
                    rd  = adv;
                end
                S_RUN: begin
                    adv = !fifo.in_empty && !fifo.out_full;
                    rd  = adv;
                    wr  = adv;
                end
                S_FLUSH: begin
                    adv = !fifo.out_full;
                    wr  = adv;
                end
                default: ;
            endcase
        end
    end

    assign last   = (state_q == S_FLUSH) && (k_q == KW'(KMAX));
    assign col_nx = (col_q == CW'(W - 1)) ? '0 : col_q + 1'b1;

    // Also the RAM read address, so the column shifted in next
    // cycle is already registered at the RAM output.
    always_comb begin
        col_d = col_q;
        if (rst || (adv && last)) begin
            col_d = '0;
        end else if (adv) begin
            col_d = col_nx;
        end
    end

    assign bot = rd ? fifo.in_dout : '0;

    // lb[sel] holds row r-2 and takes row r; roles swap at row end.
    line_buffer #(.DEPTH(W), .WIDTH(PX_WIDTH), .AW(CW)) u_lb0 (
        .clk     (clk),
        .we_i    (adv && !sel_q),
        .waddr_i (col_q),
        .wdata_i (bot),
        .raddr_i (col_d),
        .rdata_o (lb0_rd)
    );

    line_buffer #(.DEPTH(W), .WIDTH(PX_WIDTH), .AW(CW)) u_lb1 (
        .clk     (clk),
        .we_i    (adv && sel_q),
        .waddr_i (col_q),
        .wdata_i (bot),
        .raddr_i (col_d),
        .rdata_o (lb1_rd)
    );

    assign top = sel_q ? lb1_rd : lb0_rd;
    assign mid = sel_q ? lb0_rd : lb1_rd;

    always_comb begin
        win_p = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                win_p[r*3+c] = pix_t'(win_q[r][c]);
            end
        end
    end

    assign mag_full = grad_mag(win_p, mode_q == MODE_PREWITT,
                               pix_t'(PX_MAX), 5'(GRAD_SHIFT));

    assign border = (crow_q == '0) || (crow_q == RW'(H - 1))
                 || (ccol_q == '0) || (ccol_q == CW'(W - 1));

    always_comb begin
        px = '0;
        unique case (mode_q)
            MODE_PASS:   px = win_q[1][1];
            MODE_THRESH: if (!border && mag_full >= pix_t'(thr_q)) px = '1;
            default:     if (!border) px = mag_full[PX_WIDTH-1:0];
        endcase
    end

    assign fifo.in_rd_en  = rd;
    assign fifo.out_wr_en = wr;
    assign fifo.out_din   = wr ? px : '0;
    assign frame_done     = frame_done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FILL;
            k_q          <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= adv && last;
            if (adv) begin
                k_q <= k_q + 1'b1;
                unique case (state_q)
                    S_FILL:  if (k_q == KW'(W + 1)) state_q <= S_RUN;
                    S_RUN:   if (k_q == KW'(N - 1)) state_q <= S_FLUSH;
                    S_FLUSH: if (last) begin
                        state_q <= S_FILL;
                        k_q     <= '0;
                    end
                    default: state_q <= S_FILL;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q  <= '0;
            sel_q  <= 1'b0;
            ccol_q <= '0;
            crow_q <= '0;
            mode_q <= MODE_SOBEL;
            thr_q  <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else if (adv) begin
            col_q <= col_d;
            if (col_q == CW'(W - 1)) begin
                sel_q <= ~sel_q;
            end
            if (k_q == '0) begin
                mode_q <= mode_t'(mode);
                thr_q  <= threshold;
            end
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= top;
            win_q[1][2] <= mid;
            win_q[2][2] <= bot;
            if (wr) begin
                if (last) begin
                    ccol_q <= '0;
                    crow_q <= '0;
                end else if (ccol_q == CW'(W - 1)) begin
                    ccol_q <= '0;
                    crow_q <= crow_q + 1'b1;
                end else begin
                    ccol_q <= ccol_q + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_edge_filter3x3.sv
// tb_edge_filter3x3: directed vector table plus multi-frame sequences.
// Drives the FWFT/push interface, checks pixels against a reference.
module tb_edge_filter3x3;
    localparam int W = 8;
    localparam int H = 6;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode = 2'd0;
    logic [7:0] threshold = 8'd0;
    logic       frame_done;

    edge_filter3x3_if #(.PX_WIDTH(8)) bus ();

    edge_filter3x3 #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .PX_WIDTH  (8),
        .GRAD_SHIFT(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo      (bus),
        .mode      (mode),
        .threshold (threshold),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int md;
        int thr;
        int idx;
        int exp;
    } vec_t;

    vec_t       vecs [17];
    int         imgs [2][N];
    logic [7:0] src [$];
    logic [7:0] got [$];
    int         got_cyc [$];
    int         rd_cyc [$];
    int         fd_cyc [$];
    int         sp, cyc, prot_err, sw_at;
    int         nvec, nbad;
    bit         stall_in, stall_out;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void make_img(input int kind, input int slot);
        for (int i = 0; i < N; i++) begin
            if (kind == 0) imgs[slot][i] = 100;
            else if (kind == 1) imgs[slot][i] = (i % W >= 4) ? 50 : 0;
            else if (kind == 2) imgs[slot][i] = i;
            else imgs[slot][i] = int'($urandom_range(0, 255));
        end
    endfunction

    function automatic int pa(input int s, input int r, input int c);
        return imgs[s][r*W+c];
    endfunction

    function automatic int model(input int s, input int md,
                                 input int thr, input int idx);
        int r, c, mw, gx, gy, m;
        r = idx / W;
        c = idx % W;
        if (md == 3) return imgs[s][idx];
        if (r == 0 || r == H-1 || c == 0 || c == W-1) return 0;
        mw = (md == 1) ? 1 : 2;
        gx = pa(s,r-1,c+1) + mw*pa(s,r,c+1) + pa(s,r+1,c+1)
           - pa(s,r-1,c-1) - mw*pa(s,r,c-1) - pa(s,r+1,c-1);
        gy = pa(s,r+1,c-1) + mw*pa(s,r+1,c) + pa(s,r+1,c+1)
           - pa(s,r-1,c-1) - mw*pa(s,r-1,c) - pa(s,r-1,c+1);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        m = (gx + gy) / 2;
        if (m > 255) m = 255;
        if (md == 2) return (m >= thr) ? 255 : 0;
        return m;
    endfunction

    task automatic clear_all();
        src.delete();
        got.delete();
        got_cyc.delete();
        rd_cyc.delete();
        fd_cyc.delete();
        sp = 0;
    endtask

    task automatic push_img(input int slot);
        for (int i = 0; i < N; i++) src.push_back(8'(imgs[slot][i]));
    endtask

    // One clock: drive after the edge, sample at the falling edge.
    task automatic step();
        bus.in_empty = (sp >= src.size())
                    || (stall_in && $urandom_range(0, 3) == 0);
        bus.in_dout  = 8'h00;
        if (!bus.in_empty) bus.in_dout = src[sp];
        bus.out_full = stall_out && ($urandom_range(0, 3) == 0);
        @(negedge clk);
        if (bus.in_rd_en && bus.in_empty) prot_err++;
        if (bus.out_wr_en && bus.out_full) prot_err++;
        if (!bus.out_wr_en && bus.out_din != 8'h00) prot_err++;
        if (bus.in_rd_en) begin
            rd_cyc.push_back(cyc);
            sp++;
        end
        if (bus.out_wr_en) begin
            got.push_back(bus.out_din);
            got_cyc.push_back(cyc);
        end
        if (frame_done) fd_cyc.push_back(cyc);
        if (sw_at >= 0 && rd_cyc.size() == sw_at) mode = 2'd1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int nwr, input int limit);
        int n;
        n = 0;
        while (got.size() < nwr && n < limit) begin
            step();
            n++;
        end
        repeat (3) step();
    endtask

    task automatic run_frame(input int kind, input int md, input int thr);
        clear_all();
        make_img(kind, 0);
        push_img(0);
        mode      = 2'(md);
        threshold = 8'(thr);
        run(N, 3000);
    endtask

    task automatic check_frame(input string nm, input int base,
                               input int s, input int md, input int thr);
        int bad;
        bad = 0;
        for (int i = 0; i < N; i++) begin
            if (base + i >= got.size()) bad++;
            else if (int'(got[base+i]) != model(s, md, thr, i)) bad++;
        end
        chk({nm, "_pixels_wrong"}, bad, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        nvec = 0; nbad = 0; cyc = 0; prot_err = 0; sw_at = -1;
        stall_in = 1'b0; stall_out = 1'b0;
        clear_all();
        vecs[0]  = '{0, 0,   0,  9,   0};
        vecs[1]  = '{0, 0,   0, 27,   0};
        vecs[2]  = '{1, 0,   0, 11, 100};
        vecs[3]  = '{1, 0,   0, 12, 100};
        vecs[4]  = '{1, 0,   0, 13,   0};
        vecs[5]  = '{1, 0,   0,  3,   0};
        vecs[6]  = '{1, 0,   0, 43,   0};
        vecs[7]  = '{1, 0,   0, 36, 100};
        vecs[8]  = '{1, 1,   0, 19,  75};
        vecs[9]  = '{1, 2,  90, 20, 255};
        vecs[10] = '{1, 2, 101, 20,   0};
        vecs[11] = '{1, 2,  90, 10,   0};
        vecs[12] = '{2, 3,   0,  0,   0};
        vecs[13] = '{2, 3,   0, 47,  47};
        vecs[14] = '{2, 0,   0,  9,  36};
        vecs[15] = '{2, 1,   0, 18,  27};
        vecs[16] = '{1, 3,   0, 12,  50};

        bus.in_empty = 1'b0;
        bus.in_dout  = 8'h55;
        bus.out_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_rd_en", int'(bus.in_rd_en), 0);
        chk("reset_wr_en", int'(bus.out_wr_en), 0);
        chk("reset_out_din", int'(bus.out_din), 0);
        chk("reset_frame_done", int'(frame_done), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_frame(0, 0, 0);
        chk("const_writes", got.size(), N);
        check_frame("const", 0, 0, 0, 0);
        chk("const_frame_done_count", fd_cyc.size(), 1);
        if (fd_cyc.size() > 0 && got_cyc.size() == N)
            chk("const_frame_done_cycle", fd_cyc[0], got_cyc[N-1] + 1);
        else
            chk("const_frame_done_cycle", -1, 0);

        for (int i = 0; i < 17; i++) begin
            run_frame(vecs[i].kind, vecs[i].md, vecs[i].thr);
            chk($sformatf("vec%0d_writes", i), got.size(), N);
            if (got.size() > vecs[i].idx)
                chk($sformatf("vec%0d_px%0d", i, vecs[i].idx),
                    int'(got[vecs[i].idx]), vecs[i].exp);
            else
                chk($sformatf("vec%0d_px%0d", i, vecs[i].idx), -1,
                    vecs[i].exp);
            check_frame($sformatf("vec%0d", i), 0, 0,
                        vecs[i].md, vecs[i].thr);
        end

        run_frame(2, 3, 0);
        if (got_cyc.size() == N && rd_cyc.size() == N) begin
            chk("ramp_first_write_cycle", got_cyc[0], rd_cyc[10]);
            chk("ramp_write_span", got_cyc[N-1] - got_cyc[0], N - 1);
        end else begin
            chk("ramp_counts", got_cyc.size() + rd_cyc.size(), 2 * N);
        end

        clear_all();
        make_img(3, 0);
        make_img(3, 1);
        push_img(0);
        push_img(1);
        mode = 2'd0;
        threshold = 8'd0;
        stall_in = 1'b1;
        stall_out = 1'b1;
        sw_at = 20;
        run(2 * N, 5000);
        repeat (2) step();
        sw_at = -1;
        stall_in = 1'b0;
        stall_out = 1'b0;
        chk("stall_writes", got.size(), 2 * N);
        chk("stall_reads", rd_cyc.size(), 2 * N);
        chk("stall_frame_done_count", fd_cyc.size(), 2);
        check_frame("stall_f1_sobel", 0, 0, 0, 0);
        check_frame("stall_f2_prewitt", N, 1, 1, 0);

        clear_all();
        make_img(2, 0);
        push_img(0);
        mode = 2'd3;
        n = 0;
        while (rd_cyc.size() < 20 && n < 500) begin
            step();
            n++;
        end
        chk("rst_reads_before", rd_cyc.size(), 20);
        rst = 1'b1;
        bus.in_empty = 1'b0;
        bus.in_dout  = 8'h77;
        bus.out_full = 1'b0;
        @(negedge clk);
        chk("midrst_rd_en", int'(bus.in_rd_en), 0);
        chk("midrst_wr_en", int'(bus.out_wr_en), 0);
        chk("midrst_out_din", int'(bus.out_din), 0);
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        run_frame(3, 0, 0);
        chk("after_rst_writes", got.size(), N);
        check_frame("after_rst", 0, 0, 0, 0);
        chk("after_rst_frame_done_count", fd_cyc.size(), 1);

        chk("handshake_protocol_errors", prot_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
